// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 16-bit, 8-register pipelined MIPS.
// It detects load-use hazards, inserts bubbles on a hazard or flush, and keeps saturating debug counters.
module id_ex_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       instr_id,
  input  logic [DATA_W-1:0] pc1_id,
  input  logic [DATA_W-1:0] rd1_id,
  input  logic [DATA_W-1:0] rd2_id,
  input  logic              RegWrite_id,
  input  logic              RegDst_id,
  input  logic              ALUSrc_id,
  input  logic              Branch_id,
  input  logic              MemWrite_id,
  input  logic              MemRead_id,
  input  logic              MemtoReg_id,
  input  logic [1:0]        ALUOp_id,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_RegWrite,
  output logic              ex_RegDst,
  output logic              ex_ALUSrc,
  output logic              ex_Branch,
  output logic              ex_MemWrite,
  output logic              ex_MemRead,
  output logic              ex_MemtoReg,
  output logic [1:0]        ex_ALUOp,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [3:0]        ex_funct,
  output logic [DATA_W-1:0] ex_pc1,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int unsigned IMM_W = 7;

  logic [2:0]        opcode;
  logic [REG_AW-1:0] rsId;
  logic [REG_AW-1:0] rtId;
  logic [REG_AW-1:0] rdId;
  logic [DATA_W-1:0] immExt;
  logic              usesRt;
  logic              hazard;
  logic              bubble;
  logic              flushEvent;

  assign opcode = instr_id[15:13];
  assign rsId   = REG_AW'(instr_id[12:10]);
  assign rtId   = REG_AW'(instr_id[9:7]);
  assign rdId   = REG_AW'(instr_id[6:4]);
  assign immExt = {{(DATA_W-IMM_W){instr_id[6]}}, instr_id[6:0]};

  // R-type, BEQ and store read rt as a source; everything else only reads rs.
  assign usesRt = (opcode == 3'd0) | (opcode == 3'd2) | (opcode == 3'd6);

  assign hazard = ex_valid & ex_MemRead & (ex_rt != '0) &
                  ((ex_rt == rsId) | (usesRt & (ex_rt == rtId)));

  // A flush kills the consumer anyway, so it never needs to be held.
  assign stall      = hazard & ~flush & ~reset;
  assign bubble     = flush | hazard;
  assign flushEvent = flush & (instr_id != 16'd0);

  // Pipeline register: data fields always load; controls are zeroed for a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_RegDst   <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_ALUOp    <= 2'b00;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_funct    <= 4'd0;
      ex_pc1      <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      ex_rd1   <= rd1_id;
      ex_rd2   <= rd2_id;
      ex_imm   <= immExt;
      ex_rs    <= rsId;
      ex_rt    <= rtId;
      ex_rd    <= rdId;
      ex_funct <= instr_id[3:0];
      ex_pc1   <= pc1_id;
      if (bubble) begin
        ex_valid    <= 1'b0;
        ex_RegWrite <= 1'b0;
        ex_RegDst   <= 1'b0;
        ex_ALUSrc   <= 1'b0;
        ex_Branch   <= 1'b0;
        ex_MemWrite <= 1'b0;
        ex_MemRead  <= 1'b0;
        ex_MemtoReg <= 1'b0;
        ex_ALUOp    <= 2'b00;
      end else begin
        ex_valid    <= (instr_id != 16'd0);
        ex_RegWrite <= RegWrite_id;
        ex_RegDst   <= RegDst_id;
        ex_ALUSrc   <= ALUSrc_id;
        ex_Branch   <= Branch_id;
        ex_MemWrite <= MemWrite_id;
        ex_MemRead  <= MemRead_id;
        ex_MemtoReg <= MemtoReg_id;
        ex_ALUOp    <= ALUOp_id;
      end
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (flushEvent && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver queues hand-computed expectations and the monitor checks each EX update.
module tb_id_ex_stage;

  localparam int unsigned CW = 4;

  localparam int KRESET  = 0;
  localparam int KBUBBLE = 1;
  localparam int KLOAD   = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [15:0]   instr_id;
  logic [15:0]   pc1_id, rd1_id, rd2_id;
  logic          RegWrite_id, RegDst_id, ALUSrc_id, Branch_id, MemWrite_id, MemRead_id, MemtoReg_id;
  logic [1:0]    ALUOp_id;
  logic          flush;
  logic          stall, ex_valid;
  logic          ex_RegWrite, ex_RegDst, ex_ALUSrc, ex_Branch, ex_MemWrite, ex_MemRead, ex_MemtoReg;
  logic [1:0]    ex_ALUOp;
  logic [15:0]   ex_rd1, ex_rd2, ex_imm, ex_pc1;
  logic [2:0]    ex_rs, ex_rt, ex_rd;
  logic [3:0]    ex_funct;
  logic [CW-1:0] stall_count, flush_count;

  id_ex_stage #(.DATA_W(16), .REG_AW(3), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .instr_id(instr_id), .pc1_id(pc1_id),
    .rd1_id(rd1_id), .rd2_id(rd2_id),
    .RegWrite_id(RegWrite_id), .RegDst_id(RegDst_id), .ALUSrc_id(ALUSrc_id),
    .Branch_id(Branch_id), .MemWrite_id(MemWrite_id), .MemRead_id(MemRead_id),
    .MemtoReg_id(MemtoReg_id), .ALUOp_id(ALUOp_id), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_RegDst(ex_RegDst),
    .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch), .ex_MemWrite(ex_MemWrite),
    .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg), .ex_ALUOp(ex_ALUOp),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_pc1(ex_pc1),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    string         nm;
    int            kind;
    logic          stl;
    logic          vld;
    logic [6:0]    ctl;
    logic [1:0]    aop;
    logic [15:0]   rd1, rd2, pc1, imm;
    logic [2:0]    rs, rt, rd;
    logic [3:0]    fn;
    logic [CW-1:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int   passCnt  = 0;
  int   totalCnt = 0;

  // Controls packed as {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemRead, MemtoReg}.
  localparam logic [6:0] C_ADDI  = 7'b1010000;
  localparam logic [6:0] C_LOAD  = 7'b1010011;
  localparam logic [6:0] C_RTYPE = 7'b1100000;
  localparam logic [6:0] C_STORE = 7'b0010100;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s.%s got=%h expected=%h", nm, fld, act, exp);
  endtask

  task automatic issue(input string nm, input logic rst, input logic [15:0] ins,
                       input logic [6:0] ctl, input logic [1:0] aop, input logic fl,
                       input int kind, input logic expStall, input logic expValid,
                       input logic [15:0] expImm, input logic [CW-1:0] expSc,
                       input logic [CW-1:0] expFc);
    exp_t e;
    @(negedge clock);
    reset = rst; instr_id = ins; flush = fl;
    {RegWrite_id, RegDst_id, ALUSrc_id, Branch_id, MemWrite_id, MemRead_id, MemtoReg_id} = ctl;
    ALUOp_id = aop;
    rd1_id = 16'($urandom); rd2_id = 16'($urandom); pc1_id = 16'($urandom);
    e.nm = nm; e.kind = kind; e.stl = expStall; e.vld = expValid;
    e.sc = expSc; e.fc = expFc;
    e.ctl = (kind == KLOAD) ? ctl : 7'd0;
    e.aop = (kind == KLOAD) ? aop : 2'd0;
    e.rd1 = rd1_id; e.rd2 = rd2_id; e.pc1 = pc1_id; e.imm = expImm;
    e.rs = ins[12:10]; e.rt = ins[9:7]; e.rd = ins[6:4]; e.fn = ins[3:0];
    if (kind == KRESET) begin
      e.rd1 = '0; e.rd2 = '0; e.pc1 = '0; e.imm = '0;
      e.rs = '0; e.rt = '0; e.rd = '0; e.fn = '0;
    end
    q.push_back(e);
  endtask

  // Monitor: stall is sampled once ID inputs settle; ex_* just after the following edge.
  initial begin
    logic sStall;
    exp_t e;
    forever begin
      @(negedge clock); #3;
      sStall = stall;
      @(posedge clock); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "stall", 32'(sStall), 32'(e.stl));
        chk(e.nm, "ex_valid", 32'(ex_valid), 32'(e.vld));
        chk(e.nm, "ctl", 32'({ex_RegWrite, ex_RegDst, ex_ALUSrc, ex_Branch, ex_MemWrite,
                              ex_MemRead, ex_MemtoReg}), 32'(e.ctl));
        chk(e.nm, "ex_ALUOp", 32'(ex_ALUOp), 32'(e.aop));
        chk(e.nm, "stall_count", 32'(stall_count), 32'(e.sc));
        chk(e.nm, "flush_count", 32'(flush_count), 32'(e.fc));
        if (e.kind != KBUBBLE) begin
          chk(e.nm, "ex_rd1", 32'(ex_rd1), 32'(e.rd1));
          chk(e.nm, "ex_rd2", 32'(ex_rd2), 32'(e.rd2));
          chk(e.nm, "ex_pc1", 32'(ex_pc1), 32'(e.pc1));
          chk(e.nm, "ex_imm", 32'(ex_imm), 32'(e.imm));
          chk(e.nm, "ex_rs", 32'(ex_rs), 32'(e.rs));
          chk(e.nm, "ex_rt", 32'(ex_rt), 32'(e.rt));
          chk(e.nm, "ex_rd", 32'(ex_rd), 32'(e.rd));
          chk(e.nm, "ex_funct", 32'(ex_funct), 32'(e.fn));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [CW-1:0] sc;
    reset = 1'b1; instr_id = '0; flush = 1'b0; ALUOp_id = '0;
    rd1_id = '0; rd2_id = '0; pc1_id = '0;
    {RegWrite_id, RegDst_id, ALUSrc_id, Branch_id, MemWrite_id, MemRead_id, MemtoReg_id} = '0;

    // Reset with random ID inputs
    issue("rst0", 1, 16'($urandom), 7'($urandom), 2'($urandom), 1'($urandom), KRESET, 0, 0, 16'h0, 0, 0);
    issue("rst1", 1, 16'($urandom), 7'($urandom), 2'($urandom), 1'($urandom), KRESET, 0, 0, 16'h0, 0, 0);

    // Basic addi loads and sign extension
    issue("addi5",   0, 16'h6105, C_ADDI, 2'b00, 0, KLOAD, 0, 1, 16'h0005, 0, 0);
    issue("addi7f",  0, 16'h607F, C_ADDI, 2'b00, 0, KLOAD, 0, 1, 16'hFFFF, 0, 0);

    // Load r3 then add r4,r3,r1: one stall cycle, bubble, then the add
    issue("ld_r3",   0, 16'hA580, C_LOAD,  2'b00, 0, KLOAD,   0, 1, 16'h0000, 1'b0, 0);
    issue("add_stl", 0, 16'h0CC0, C_RTYPE, 2'b10, 0, KBUBBLE, 1, 0, 16'hFFC0, 1, 0);
    issue("add_go",  0, 16'h0CC0, C_RTYPE, 2'b10, 0, KLOAD,   0, 1, 16'hFFC0, 1, 0);

    // Load to r0 never stalls; store rt match stalls; addi rt match does not
    issue("ld_r0",   0, 16'hA400, C_LOAD,  2'b00, 0, KLOAD,   0, 1, 16'h0000, 1, 0);
    issue("add_r0",  0, 16'h0040, C_RTYPE, 2'b10, 0, KLOAD,   0, 1, 16'hFFC0, 1, 0);
    issue("ld_r3b",  0, 16'hA580, C_LOAD,  2'b00, 0, KLOAD,   0, 1, 16'h0000, 1, 0);
    issue("st_stl",  0, 16'hC981, C_STORE, 2'b00, 0, KBUBBLE, 1, 0, 16'h0001, 2, 0);
    issue("st_go",   0, 16'hC981, C_STORE, 2'b00, 0, KLOAD,   0, 1, 16'h0001, 2, 0);
    issue("ld_r3c",  0, 16'hA580, C_LOAD,  2'b00, 0, KLOAD,   0, 1, 16'h0000, 2, 0);
    issue("addi_rt", 0, 16'h6987, C_ADDI,  2'b00, 0, KLOAD,   0, 1, 16'h0007, 2, 0);

    // Hazard and flush together: flush wins, no stall
    issue("ld_r3d",  0, 16'hA580, C_LOAD,  2'b00, 0, KLOAD,   0, 1, 16'h0000, 2, 0);
    issue("add_fl",  0, 16'h0CC0, C_RTYPE, 2'b10, 1, KBUBBLE, 0, 0, 16'hFFC0, 2, 1);
    issue("add_af",  0, 16'h0CC0, C_RTYPE, 2'b10, 0, KLOAD,   0, 1, 16'hFFC0, 2, 1);
    issue("nop_fl",  0, 16'h0000, 7'd0,    2'b00, 1, KBUBBLE, 0, 0, 16'h0000, 2, 1);
    issue("nop",     0, 16'h0000, 7'd0,    2'b00, 0, KLOAD,   0, 0, 16'h0000, 2, 1);

    // Reset during a would-be stall clears everything
    issue("ld_r3e",  0, 16'hA580, C_LOAD,  2'b00, 0, KLOAD,   0, 1, 16'h0000, 2, 1);
    issue("add_rst", 1, 16'h0CC0, C_RTYPE, 2'b10, 0, KRESET,  0, 0, 16'h0000, 0, 0);
    issue("add_pr",  0, 16'h0CC0, C_RTYPE, 2'b10, 0, KLOAD,   0, 1, 16'hFFC0, 0, 0);

    // Saturate stall_count with 16 load-use pairs
    for (int i = 0; i < 16; i++) begin
      sc = (i >= 14) ? 4'hF : 4'(i + 1);
      issue("sat_ld",  0, 16'hA580, C_LOAD,  2'b00, 0, KLOAD,   0, 1, 16'h0000, (i == 0) ? 4'd0 : ((i >= 15) ? 4'hF : 4'(i)), 0);
      issue("sat_stl", 0, 16'h0CC0, C_RTYPE, 2'b10, 0, KBUBBLE, 1, 0, 16'hFFC0, sc, 0);
      issue("sat_go",  0, 16'h0CC0, C_RTYPE, 2'b10, 0, KLOAD,   0, 1, 16'hFFC0, sc, 0);
    end

    @(negedge clock);
    @(posedge clock); #5;
    totalCnt++;
    if (q.size() == 0) passCnt++;
    else $display("FAIL drain got=%0d expected=0 pending", q.size());

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
